// File: rtl/spi_rx_check_pkg.sv
// Shared defaults, FSM encoding and SETTLE timing for the SPI receive-checker.
`timescale 1ns/1ps
package spi_rx_check_pkg;

    localparam int unsigned W_DEF      = 64;
    localparam int unsigned CW_DEF     = 16;
    localparam int unsigned SETTLE_LEN = 2;
    localparam int unsigned SETTLE_CW  = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACTIVE  = 2'd1,
        ST_SETTLE  = 2'd2,
        ST_COMPARE = 2'd3
    } state_e;

endpackage

// File: rtl/spi_rx_check_sync2.sv
// Two-flop synchroniser for the asynchronous SPI frame strobe; resets to the idle-high level.
`timescale 1ns/1ps
module spi_rx_check_sync2 (
    input  logic clk,
    input  logic clr_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/spi_rx_check.sv
// Compares each received SPI frame against the expected word and keeps frame/error statistics.
// Optional feature: define SPI_RX_CHECK_BITERR_EN to add the accumulated bit-error counter.
`timescale 1ns/1ps
module spi_rx_check
    import spi_rx_check_pkg::*;
#(
    parameter int unsigned W  = W_DEF,
    parameter int unsigned CW = CW_DEF
) (
    input  logic          clk,
    input  logic          clr_n,
    input  logic          load,
    input  logic [W-1:0]  rx_dat,
    input  logic [W-1:0]  exp_dat,
    input  logic          clr_cnt,
    output logic [CW-1:0] frame_cnt,
    output logic [CW-1:0] err_cnt,
    output logic          frame_ok,
    output logic          err_sticky,
    output logic          done,
    output logic          busy
`ifdef SPI_RX_CHECK_BITERR_EN
    ,
    output logic [CW-1:0] biterr_cnt
`endif
);

    localparam logic [CW-1:0] CNT_MAX = '1;

    state_e               state_q;
    state_e               state_d;
    logic                 load_s2;
    logic                 load_s3;
    logic [1:0]           fill;
    logic                 armed;
    logic                 rise_c;
    logic                 fall_c;
    logic                 match_c;
    logic [SETTLE_CW-1:0] settle_cnt;
    logic [W-1:0]         rx_q;
    logic [W-1:0]         exp_q;

    spi_rx_check_sync2 u_sync2 (
        .clk   (clk),
        .clr_n (clr_n),
        .d     (load),
        .q     (load_s2)
    );

    // Third flop for edge detection; fill/armed suppress the fake fall a reset-to-high synchroniser
    // would show when load is already low at reset release.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            load_s3 <= 1'b1;
            fill    <= 2'd0;
            armed   <= 1'b0;
        end else begin
            load_s3 <= load_s2;
            if (fill != 2'd2) begin
                fill <= fill + 2'd1;
            end
            if (fill == 2'd2 && load_s2) begin
                armed <= 1'b1;
            end
        end
    end

    assign rise_c  = load_s2 & ~load_s3;
    assign fall_c  = load_s3 & ~load_s2;
    assign match_c = (rx_q == exp_q);

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (fall_c && armed) state_d = ST_ACTIVE;
            ST_ACTIVE:  if (rise_c) state_d = ST_SETTLE;
            ST_SETTLE:  if (settle_cnt == SETTLE_CW'(SETTLE_LEN - 1)) state_d = ST_COMPARE;
            ST_COMPARE: state_d = load_s2 ? ST_IDLE : ST_ACTIVE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Settle timer and data capture on the way into COMPARE.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            settle_cnt <= '0;
            rx_q       <= '0;
            exp_q      <= '0;
        end else begin
            settle_cnt <= (state_q == ST_SETTLE) ? settle_cnt + SETTLE_CW'(1) : '0;
            if (state_q == ST_SETTLE && state_d == ST_COMPARE) begin
                rx_q  <= rx_dat;
                exp_q <= exp_dat;
            end
        end
    end

    // Result and statistics; a counter clear beats a simultaneous compare update.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            frame_cnt  <= '0;
            err_cnt    <= '0;
            frame_ok   <= 1'b1;
            err_sticky <= 1'b0;
            done       <= 1'b0;
            busy       <= 1'b0;
        end else begin
            done <= (state_q == ST_COMPARE);
            busy <= (state_d == ST_ACTIVE);
            if (state_q == ST_COMPARE) begin
                frame_ok <= match_c;
            end
            if (clr_cnt) begin
                frame_cnt  <= '0;
                err_cnt    <= '0;
                err_sticky <= 1'b0;
            end else if (state_q == ST_COMPARE) begin
                if (frame_cnt != CNT_MAX) begin
                    frame_cnt <= frame_cnt + CW'(1);
                end
                if (!match_c) begin
                    err_sticky <= 1'b1;
                    if (err_cnt != CNT_MAX) begin
                        err_cnt <= err_cnt + CW'(1);
                    end
                end
            end
        end
    end

`ifdef SPI_RX_CHECK_BITERR_EN
    localparam int unsigned PW = $clog2(W + 1);
    localparam int unsigned SW = ((CW > PW) ? CW : PW) + 1;

    function automatic logic [PW-1:0] popcount(input logic [W-1:0] v);
        logic [PW-1:0] n;
        n = '0;
        for (int i = 0; i < W; i++) begin
            n = n + PW'(v[i]);
        end
        return n;
    endfunction

    logic [SW-1:0] bit_sum_c;
    assign bit_sum_c = SW'(biterr_cnt) + SW'(popcount(rx_q ^ exp_q));

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            biterr_cnt <= '0;
        end else if (clr_cnt) begin
            biterr_cnt <= '0;
        end else if (state_q == ST_COMPARE) begin
            biterr_cnt <= (bit_sum_c > SW'(CNT_MAX)) ? CNT_MAX : CW'(bit_sum_c);
        end
    end
`endif

endmodule

// File: tb/tb_spi_rx_check.sv
// Directed self-checking bench for spi_rx_check (full-width instance plus a CW=4 saturation instance).
`timescale 1ns/1ps
module tb_spi_rx_check;

    localparam int unsigned W = 64;

    logic          clk = 1'b0;
    logic          clr_n = 1'b0;
    logic          load = 1'b1;
    logic          load_s = 1'b1;
    logic          clr_cnt = 1'b0;
    logic [W-1:0]  rx_dat = '0;
    logic [W-1:0]  exp_dat = '0;

    logic [15:0]   frame_cnt, err_cnt;
    logic          frame_ok, err_sticky, done, busy;
    logic [3:0]    frame_cnt_s, err_cnt_s;
    logic          frame_ok_s, err_sticky_s, done_s, busy_s;
`ifdef SPI_RX_CHECK_BITERR_EN
    logic [15:0]   biterr_cnt;
    logic [3:0]    biterr_cnt_s;
`endif

    int checks = 0;
    int errors = 0;
    int ndone = 0;
    int ndone_s = 0;

    always #5 clk = ~clk;

    spi_rx_check #(.W(W), .CW(16)) dut (
        .clk        (clk),
        .clr_n      (clr_n),
        .load       (load),
        .rx_dat     (rx_dat),
        .exp_dat    (exp_dat),
        .clr_cnt    (clr_cnt),
        .frame_cnt  (frame_cnt),
        .err_cnt    (err_cnt),
        .frame_ok   (frame_ok),
        .err_sticky (err_sticky),
        .done       (done),
        .busy       (busy)
`ifdef SPI_RX_CHECK_BITERR_EN
        ,
        .biterr_cnt (biterr_cnt)
`endif
    );

    spi_rx_check #(.W(W), .CW(4)) dut_s (
        .clk        (clk),
        .clr_n      (clr_n),
        .load       (load_s),
        .rx_dat     (rx_dat),
        .exp_dat    (exp_dat),
        .clr_cnt    (clr_cnt),
        .frame_cnt  (frame_cnt_s),
        .err_cnt    (err_cnt_s),
        .frame_ok   (frame_ok_s),
        .err_sticky (err_sticky_s),
        .done       (done_s),
        .busy       (busy_s)
`ifdef SPI_RX_CHECK_BITERR_EN
        ,
        .biterr_cnt (biterr_cnt_s)
`endif
    );

    always @(negedge clk) begin
        if (done === 1'b1) ndone++;
        if (done_s === 1'b1) ndone_s++;
    end

    // Posedges from the load rise (driven at a negedge) until done is seen; -1 on timeout.
    task automatic wait_done(input bit sat, output int lat);
        lat = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            lat++;
            if ((sat ? done_s : done) === 1'b1) return;
        end
        lat = -1;
    endtask

    task automatic run_frame(input int low_clks, input bit sat, output int lat);
        @(negedge clk);
        if (sat) load_s = 1'b0; else load = 1'b0;
        repeat (low_clks) @(negedge clk);
        if (sat) load_s = 1'b1; else load = 1'b1;
        wait_done(sat, lat);
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        clr_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL reset_frame_cnt got %0d exp 0", frame_cnt); end
        checks++; if (err_cnt !== 16'd0) begin errors++; $display("FAIL reset_err_cnt got %0d exp 0", err_cnt); end
        checks++; if (frame_ok !== 1'b1) begin errors++; $display("FAIL reset_frame_ok got %b exp 1", frame_ok); end
        checks++; if (err_sticky !== 1'b0) begin errors++; $display("FAIL reset_err_sticky got %b exp 0", err_sticky); end
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL reset_done_busy got %b%b exp 00", done, busy); end
        clr_n = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if (busy !== 1'b0 || frame_cnt_s !== 4'd0) begin errors++; $display("FAIL post_reset_idle got busy=%b cnt_s=%0d exp 0 0", busy, frame_cnt_s); end
    endtask

    task automatic test_match();
        int lat;
        int nd0;
        rx_dat  = 64'hA5A5_0F0F_1234_5678;
        exp_dat = 64'hA5A5_0F0F_1234_5678;
        nd0 = ndone;
        @(negedge clk); load = 1'b0;
        repeat (50) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL match_busy got %b exp 1", busy); end
        repeat (50) @(negedge clk);
        load = 1'b1;
        wait_done(1'b0, lat);
        checks++; if (lat != 6) begin errors++; $display("FAIL match_latency got %0d exp 6", lat); end
        checks++; if (frame_cnt !== 16'd1 || err_cnt !== 16'd0) begin errors++; $display("FAIL match_counts got %0d/%0d exp 1/0", frame_cnt, err_cnt); end
        checks++; if (frame_ok !== 1'b1) begin errors++; $display("FAIL match_frame_ok got %b exp 1", frame_ok); end
        @(negedge clk);
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL match_done_width got done=%b busy=%b exp 0 0", done, busy); end
        repeat (3) @(negedge clk);
        checks++; if (ndone - nd0 != 1) begin errors++; $display("FAIL match_done_pulses got %0d exp 1", ndone - nd0); end
    endtask

    task automatic test_mismatch();
        int lat;
        exp_dat = 64'hA5A5_0F0F_1234_5678;
        rx_dat  = 64'hA5A5_0F0F_1234_5679;
        run_frame(30, 1'b0, lat);
        checks++; if (lat != 6) begin errors++; $display("FAIL mismatch_latency got %0d exp 6", lat); end
        checks++; if (frame_cnt !== 16'd2 || err_cnt !== 16'd1) begin errors++; $display("FAIL mismatch_counts got %0d/%0d exp 2/1", frame_cnt, err_cnt); end
        checks++; if (frame_ok !== 1'b0 || err_sticky !== 1'b1) begin errors++; $display("FAIL mismatch_flags got ok=%b sticky=%b exp 0 1", frame_ok, err_sticky); end
`ifdef SPI_RX_CHECK_BITERR_EN
        checks++; if (biterr_cnt !== 16'd1) begin errors++; $display("FAIL mismatch_biterr got %0d exp 1", biterr_cnt); end
`endif
        rx_dat = exp_dat;
        run_frame(30, 1'b0, lat);
        checks++; if (frame_cnt !== 16'd3 || err_cnt !== 16'd1) begin errors++; $display("FAIL rematch_counts got %0d/%0d exp 3/1", frame_cnt, err_cnt); end
        checks++; if (frame_ok !== 1'b1 || err_sticky !== 1'b1) begin errors++; $display("FAIL rematch_flags got ok=%b sticky=%b exp 1 1", frame_ok, err_sticky); end
    endtask

    task automatic test_back_to_back();
        int lat;
        int nd0;
        nd0 = ndone;
        @(negedge clk); load = 1'b0;
        repeat (20) @(negedge clk);
        load = 1'b1;
        repeat (2) @(negedge clk);
        load = 1'b0;
        wait_done(1'b0, lat);
        checks++; if (lat != 4) begin errors++; $display("FAIL b2b_first_latency got %0d exp 4", lat); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_direct_active got busy=%b exp 1", busy); end
        repeat (10) @(negedge clk);
        load = 1'b1;
        wait_done(1'b0, lat);
        checks++; if (lat != 6) begin errors++; $display("FAIL b2b_second_latency got %0d exp 6", lat); end
        repeat (3) @(negedge clk);
        checks++; if (frame_cnt !== 16'd5 || ndone - nd0 != 2) begin errors++; $display("FAIL b2b_counts got cnt=%0d pulses=%0d exp 5 2", frame_cnt, ndone - nd0); end
    endtask

    task automatic test_clr_cnt();
        int lat;
        @(negedge clk); clr_cnt = 1'b1;
        @(negedge clk); clr_cnt = 1'b0;
        checks++; if (frame_cnt !== 16'd0 || err_cnt !== 16'd0 || err_sticky !== 1'b0) begin errors++; $display("FAIL clr_idle got %0d/%0d/%b exp 0/0/0", frame_cnt, err_cnt, err_sticky); end
`ifdef SPI_RX_CHECK_BITERR_EN
        checks++; if (biterr_cnt !== 16'd0) begin errors++; $display("FAIL clr_biterr got %0d exp 0", biterr_cnt); end
`endif
        rx_dat = exp_dat;
        @(negedge clk); load = 1'b0;
        repeat (10) @(negedge clk);
        clr_cnt = 1'b1;
        @(negedge clk); clr_cnt = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL clr_active_state got busy=%b exp 1", busy); end
        repeat (10) @(negedge clk);
        load = 1'b1;
        wait_done(1'b0, lat);
        repeat (2) @(negedge clk);
        checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL clr_active_frame got %0d exp 1", frame_cnt); end
        // Clear lands exactly in the COMPARE cycle of a mismatching frame.
        rx_dat = exp_dat ^ 64'h1;
        @(negedge clk); load = 1'b0;
        repeat (20) @(negedge clk);
        load = 1'b1;
        repeat (5) @(negedge clk);
        clr_cnt = 1'b1;
        @(negedge clk); clr_cnt = 1'b0;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL clr_compare_done got %b exp 1", done); end
        checks++; if (frame_cnt !== 16'd0 || err_cnt !== 16'd0 || err_sticky !== 1'b0) begin errors++; $display("FAIL clr_compare_wins got %0d/%0d/%b exp 0/0/0", frame_cnt, err_cnt, err_sticky); end
        checks++; if (frame_ok !== 1'b0) begin errors++; $display("FAIL clr_compare_frame_ok got %b exp 0", frame_ok); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_saturation();
        int lat;
        int nd0;
        int tmo;
        tmo = 0;
        nd0 = ndone_s;
        exp_dat = 64'h0123_4567_89AB_CDEF;
        rx_dat  = exp_dat ^ 64'h1;
        for (int f = 0; f < 20; f++) begin
            run_frame(5, 1'b1, lat);
            if (lat < 0) tmo++;
        end
        repeat (2) @(negedge clk);
        checks++; if (tmo != 0) begin errors++; $display("FAIL sat_timeouts got %0d exp 0", tmo); end
        checks++; if (frame_cnt_s !== 4'd15 || err_cnt_s !== 4'd15) begin errors++; $display("FAIL sat_counts got %0d/%0d exp 15/15", frame_cnt_s, err_cnt_s); end
        checks++; if (ndone_s - nd0 != 20) begin errors++; $display("FAIL sat_done_pulses got %0d exp 20", ndone_s - nd0); end
        checks++; if (frame_ok_s !== 1'b0 || err_sticky_s !== 1'b1) begin errors++; $display("FAIL sat_flags got ok=%b sticky=%b exp 0 1", frame_ok_s, err_sticky_s); end
`ifdef SPI_RX_CHECK_BITERR_EN
        checks++; if (biterr_cnt_s !== 4'd15) begin errors++; $display("FAIL sat_biterr got %0d exp 15", biterr_cnt_s); end
`endif
    endtask

    task automatic test_reset_mid_frame();
        int nd0;
        rx_dat = exp_dat ^ 64'hFF;
        @(negedge clk); load = 1'b0;
        repeat (50) @(negedge clk);
        clr_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0 || frame_cnt_s !== 4'd0) begin errors++; $display("FAIL midreset_async got busy=%b cnt_s=%0d exp 0 0", busy, frame_cnt_s); end
        clr_n = 1'b1;
        repeat (48) @(negedge clk);
        nd0 = ndone;
        load = 1'b1;
        repeat (15) @(negedge clk);
        checks++; if (frame_cnt !== 16'd0 || err_cnt !== 16'd0) begin errors++; $display("FAIL midreset_counts got %0d/%0d exp 0/0", frame_cnt, err_cnt); end
        checks++; if (ndone != nd0 || frame_ok !== 1'b1) begin errors++; $display("FAIL midreset_no_done got pulses=%0d ok=%b exp 0 1", ndone - nd0, frame_ok); end
    endtask

    task automatic test_glitch();
        int lat;
        int nd0;
        @(negedge clk); load = 1'b0; clr_n = 1'b0;
        repeat (2) @(negedge clk);
        clr_n = 1'b1;
        repeat (10) @(negedge clk);
        nd0 = ndone;
        load = 1'b1;
        @(negedge clk); load = 1'b0;
        repeat (12) @(negedge clk);
        checks++; if (ndone != nd0 || frame_cnt !== 16'd0 || err_cnt !== 16'd0) begin errors++; $display("FAIL glitch_ignored got pulses=%0d cnt=%0d err=%0d exp 0 0 0", ndone - nd0, frame_cnt, err_cnt); end
        clr_n = 1'b0; load = 1'b1;
        repeat (2) @(negedge clk);
        clr_n = 1'b1;
        repeat (4) @(negedge clk);
        rx_dat = exp_dat;
        run_frame(10, 1'b0, lat);
        checks++; if (lat != 6 || frame_cnt !== 16'd1 || frame_ok !== 1'b1) begin errors++; $display("FAIL recover_frame got lat=%0d cnt=%0d ok=%b exp 6 1 1", lat, frame_cnt, frame_ok); end
    endtask

    initial begin
        test_reset();
        test_match();
        test_mismatch();
        test_back_to_back();
        test_clr_cnt();
        test_saturation();
        test_reset_mid_frame();
        test_glitch();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
